free_list_ctrl: RTL and testbench
=================================

# free_list_ctrl

Allocation/recovery controller in front of the 128-entry physical-register free list. Round-robin arbitrates rename-slot allocation requests onto the list's single read port and gates commit frees onto its write port. Keeps a circular queue of read-pointer checkpoints, one per in-flight branch, and sequences pointer rollback on a mispredict. Sits between rename/ROB and the free list; the free list is instantiated beside it, not inside.

## Interface
- NUM_REQ, 2: rename requesters sharing the allocation port
- NUM_CKPT, 4: checkpoint slots (power of 2)
- PTR_W, 7: free-list pointer / physical-register width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low (0 = reset)
- alloc_req  in  NUM_REQ  per-requester allocation request
- alloc_gnt  out  NUM_REQ  one-hot grant, same cycle
- alloc_pd  out  PTR_W  granted register (fl_pd_new_out)
- commit_valid  in  1  ROB frees commit_pd
- commit_pd  in  PTR_W  register being freed
- commit_ready  out  1  free accepted this cycle
- ckpt_alloc  in  1  branch renamed; take checkpoint
- ckpt_tag  out  log2(NUM_CKPT)  tag of checkpoint taken
- ckpt_full  out  1  no free slot
- ckpt_release  in  1  oldest branch resolved correct; free head slot
- mispredict  in  1  recover to checkpoint mispredict_tag
- mispredict_tag  in  log2(NUM_CKPT)  checkpoint to restore
- busy  out  1  recovery in progress
- fl_read_en, fl_write_en, fl_data_in, fl_mispredict, fl_re_r_ptr, fl_re_w_ptr  out  drive the free list
- fl_pd_new_out, fl_empty, fl_r_ptr_out, fl_w_ptr_out  in  from the free list

## Operation
- FSM: IDLE, RECOVER, SETTLE. Reset: IDLE, all outputs 0, checkpoint queue empty (head=tail=0, count=0), RR pointer at requester 0.
- IDLE: grant highest-priority asserted req after RR pointer if !fl_empty; at most one grant/cycle; fl_read_en = |alloc_gnt; RR pointer advances past the winner on grant only.
- Commit: commit_ready = (state==IDLE). fl_write_en = commit_valid && commit_ready && commit_pd != 0 (p0 is never freed; still acknowledged).
- ckpt_alloc while !ckpt_full: write slot[tail] = post-grant read pointer (fl_r_ptr_out advanced by 1 if a grant fires this cycle, wrap 127 -> 1); ckpt_tag = tail; tail++. ckpt_alloc while full: ignored (rename must stall on ckpt_full).
- ckpt_release: head++, count--; ignored when empty. Same-cycle alloc+release: count unchanged.
- mispredict (IDLE only): latch slot[mispredict_tag]; tail = mispredict_tag+1 mod NUM_CKPT, count recomputed (flushes that slot and all younger); go RECOVER. Simultaneous ckpt_alloc/alloc_req dropped.
- RECOVER: fl_mispredict=1, fl_re_r_ptr=latched pointer, fl_re_w_ptr=fl_w_ptr_out; no grants, no commits; -> SETTLE.
- SETTLE: no grants, no commits (free-list counter settling); -> IDLE.
- mispredict outside IDLE: ignored (upstream flush guarantees none).

## Timing
- Grant, alloc_pd, fl_read_en, commit path: combinational, 0 cycles.
- ckpt_tag valid same cycle as ckpt_alloc; slot written at that edge.
- Mispredict at edge T: fl_mispredict high T+1 only; busy high T+1..T+2; grants resume T+3.
- Reset assertion mid-recovery: immediate return to IDLE, queue cleared.

## Configuration
- FREE_LIST_CTRL_STATS_EN defined: adds outputs stat_empty_stall (32-bit, cycles with any req && fl_empty), stat_recover (16-bit, recoveries entered); saturating, cleared on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package fl_pkg: preg_t (7-bit), FL_DEPTH=128, FL_WRAP_PTR=1, PREG_ZERO=0, fl_ctrl_state_e.
- Sub-module rr_arbiter (NUM_REQ-wide round-robin, grant-enable input, advance-on-grant).

## Test plan
- Reset, both req high, fl_pd_new_out=32 then 33 -> gnt 01 then 10, alloc_pd 32, 33, fl_read_en each cycle.
- fl_empty=1 with req=11 -> gnt=00, fl_read_en=0; stats counter +1/cycle when enabled.
- commit_pd=0 valid -> commit_ready=1, fl_write_en=0; commit_pd=45 -> fl_write_en=1, fl_data_in=45.
- fl_r_ptr_out=127 plus grant plus ckpt_alloc -> slot stores 1, ckpt_tag=0.
- Take 4 checkpoints -> ckpt_full=1; 5th ignored; ckpt_release -> ckpt_full=0.
- Checkpoints 0..2 hold 10,14,20; mispredict tag 1 -> T+1 fl_mispredict=1, fl_re_r_ptr=14, grants/commit_ready low T+1..T+2; next ckpt_tag=2.

Source files
------------

// File: rtl/fl_pkg.sv
// fl_pkg: shared types and constants for the free-list allocation controller.
// Used by free_list_ctrl and rr_arbiter.
package fl_pkg;

    localparam int FL_DEPTH = 128;
    localparam int PREG_W   = 7;

    typedef logic [PREG_W-1:0] preg_t;

    localparam preg_t FL_WRAP_PTR = preg_t'(1);
    localparam preg_t PREG_ZERO   = preg_t'(0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECOVER = 2'd1,
        ST_SETTLE  = 2'd2
    } fl_ctrl_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: NUM_REQ-wide round-robin arbiter with grant enable.
// The priority pointer moves just past the winner, only when a grant fires.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic [IW-1:0] win;
    logic          found;

    // Pick the first asserted request at or after the priority pointer.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                win      = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    // Advance the priority pointer past the winner on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
        end
    end

endmodule

// File: rtl/free_list_ctrl.sv
// free_list_ctrl: arbitrates rename allocations onto the free list, gates commit
// frees, keeps branch read-pointer checkpoints and sequences mispredict rollback.
// Optional FREE_LIST_CTRL_STATS_EN adds stall/recovery statistics counters.
module free_list_ctrl
    import fl_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_CKPT = 4,
    parameter int PTR_W    = $bits(preg_t),
    localparam int CW      = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] alloc_req,
    output logic [NUM_REQ-1:0] alloc_gnt,
    output logic [PTR_W-1:0]   alloc_pd,
    input  logic               commit_valid,
    input  logic [PTR_W-1:0]   commit_pd,
    output logic               commit_ready,
    input  logic               ckpt_alloc,
    output logic [CW-1:0]      ckpt_tag,
    output logic               ckpt_full,
    input  logic               ckpt_release,
    input  logic               mispredict,
    input  logic [CW-1:0]      mispredict_tag,
    output logic               busy,
    output logic               fl_read_en,
    output logic               fl_write_en,
    output logic [PTR_W-1:0]   fl_data_in,
    output logic               fl_mispredict,
    output logic [PTR_W-1:0]   fl_re_r_ptr,
    output logic [PTR_W-1:0]   fl_re_w_ptr,
    input  logic [PTR_W-1:0]   fl_pd_new_out,
    input  logic               fl_empty,
    input  logic [PTR_W-1:0]   fl_r_ptr_out,
    input  logic [PTR_W-1:0]   fl_w_ptr_out
`ifdef FREE_LIST_CTRL_STATS_EN
    ,
    output logic [31:0]        stat_empty_stall,
    output logic [15:0]        stat_recover
`endif
);

    fl_ctrl_state_e state, state_nx;

    logic [PTR_W-1:0] slots [NUM_CKPT];
    logic [PTR_W-1:0] rec_ptr;
    logic [PTR_W-1:0] next_rptr;
    logic [CW-1:0]    head;
    logic [CW-1:0]    tail;
    logic [CW:0]      count;

    logic idle;
    logic grant_en;
    logic take_mp;
    logic do_alloc;
    logic do_release;

    assign idle       = (state == ST_IDLE);
    assign take_mp    = idle && mispredict;
    assign grant_en   = idle && !fl_empty && !mispredict;
    assign ckpt_full  = (count == (CW+1)'(NUM_CKPT));
    assign ckpt_tag   = tail;
    assign do_alloc   = idle && ckpt_alloc && !ckpt_full && !mispredict;
    assign do_release = ckpt_release && (count != '0) && !take_mp;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (reset),
        .en    (grant_en),
        .req   (alloc_req),
        .gnt   (alloc_gnt)
    );

    // Allocation, commit and recovery datapath outputs.
    always_comb begin
        fl_read_en    = |alloc_gnt;
        alloc_pd      = fl_read_en ? fl_pd_new_out : '0;
        commit_ready  = idle;
        fl_write_en   = commit_valid && idle &&
                        (commit_pd != PTR_W'(PREG_ZERO));
        fl_data_in    = fl_write_en ? commit_pd : '0;
        fl_mispredict = (state == ST_RECOVER);
        fl_re_r_ptr   = fl_mispredict ? rec_ptr : '0;
        fl_re_w_ptr   = fl_mispredict ? fl_w_ptr_out : '0;
        busy          = !idle;
        next_rptr     = fl_r_ptr_out;
        if (fl_read_en) begin
            if (fl_r_ptr_out == PTR_W'(FL_DEPTH - 1)) begin
                next_rptr = PTR_W'(FL_WRAP_PTR);
            end else begin
                next_rptr = fl_r_ptr_out + PTR_W'(1);
            end
        end
    end

    // Recovery sequencer next state.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (mispredict) state_nx = ST_RECOVER;
            ST_RECOVER: state_nx = ST_SETTLE;
            ST_SETTLE:  state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Recovery sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Checkpoint queue: push on branch rename, pop on resolve, truncate on mispredict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rec_ptr <= '0;
            for (int i = 0; i < NUM_CKPT; i++) begin
                slots[i] <= '0;
            end
        end else if (take_mp) begin
            rec_ptr <= slots[mispredict_tag];
            tail    <= mispredict_tag + CW'(1);
            count   <= {1'b0, CW'(mispredict_tag - head)} + (CW+1)'(1);
        end else begin
            if (do_alloc) begin
                slots[tail] <= next_rptr;
                tail        <= tail + CW'(1);
            end
            if (do_release) begin
                head <= head + CW'(1);
            end
            if (do_alloc && !do_release) begin
                count <= count + (CW+1)'(1);
            end else if (!do_alloc && do_release) begin
                count <= count - (CW+1)'(1);
            end
        end
    end

`ifdef FREE_LIST_CTRL_STATS_EN
    // Saturating counters of empty-list stalls and recoveries entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_empty_stall <= '0;
            stat_recover     <= '0;
        end else begin
            if ((|alloc_req) && fl_empty && (stat_empty_stall != '1)) begin
                stat_empty_stall <= stat_empty_stall + 32'd1;
            end
            if (take_mp && (stat_recover != '1)) begin
                stat_recover <= stat_recover + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_free_list_ctrl.sv
// tb_free_list_ctrl: directed and randomized checks of free_list_ctrl against
// a queue-based reference model.
module tb_free_list_ctrl;

    localparam int NUM_REQ  = 2;
    localparam int NUM_CKPT = 4;
    localparam int PTR_W    = 7;
    localparam int CW       = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NUM_REQ-1:0] alloc_req = '0;
    logic [NUM_REQ-1:0] alloc_gnt;
    logic [PTR_W-1:0]   alloc_pd;
    logic               commit_valid = 1'b0;
    logic [PTR_W-1:0]   commit_pd = '0;
    logic               commit_ready;
    logic               ckpt_alloc = 1'b0;
    logic [CW-1:0]      ckpt_tag;
    logic               ckpt_full;
    logic               ckpt_release = 1'b0;
    logic               mispredict = 1'b0;
    logic [CW-1:0]      mispredict_tag = '0;
    logic               busy;
    logic               fl_read_en;
    logic               fl_write_en;
    logic [PTR_W-1:0]   fl_data_in;
    logic               fl_mispredict;
    logic [PTR_W-1:0]   fl_re_r_ptr;
    logic [PTR_W-1:0]   fl_re_w_ptr;
    logic [PTR_W-1:0]   fl_pd_new_out = '0;
    logic               fl_empty = 1'b0;
    logic [PTR_W-1:0]   fl_r_ptr_out = '0;
    logic [PTR_W-1:0]   fl_w_ptr_out = '0;
`ifdef FREE_LIST_CTRL_STATS_EN
    logic [31:0]        stat_empty_stall;
    logic [15:0]        stat_recover;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int tag;
        int ptr;
    } ck_t;

    ck_t q[$];
    int  m_rec;
    int  m_rr;
    int  m_tail;
    int  m_recptr;
    longint m_stall;
    int  m_nrec;

    free_list_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .alloc_gnt      (alloc_gnt),
        .alloc_pd       (alloc_pd),
        .commit_valid   (commit_valid),
        .commit_pd      (commit_pd),
        .commit_ready   (commit_ready),
        .ckpt_alloc     (ckpt_alloc),
        .ckpt_tag       (ckpt_tag),
        .ckpt_full      (ckpt_full),
        .ckpt_release   (ckpt_release),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .busy           (busy),
        .fl_read_en     (fl_read_en),
        .fl_write_en    (fl_write_en),
        .fl_data_in     (fl_data_in),
        .fl_mispredict  (fl_mispredict),
        .fl_re_r_ptr    (fl_re_r_ptr),
        .fl_re_w_ptr    (fl_re_w_ptr),
        .fl_pd_new_out  (fl_pd_new_out),
        .fl_empty       (fl_empty),
        .fl_r_ptr_out   (fl_r_ptr_out),
        .fl_w_ptr_out   (fl_w_ptr_out)
`ifdef FREE_LIST_CTRL_STATS_EN
        ,
        .stat_empty_stall (stat_empty_stall),
        .stat_recover     (stat_recover)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rec    = 0;
        m_rr     = 0;
        m_tail   = 0;
        m_recptr = 0;
        m_stall  = 0;
        m_nrec   = 0;
    endtask

    // Check every output against the model, then advance the model one cycle.
    task automatic check_and_update();
        int  win;
        int  j;
        int  e_gnt;
        bit  idle;
        bit  e_we;
        int  post;
        int  idx;
        bit  ok_alloc;
        idle = (m_rec == 0);
        win  = -1;
        if (idle && !fl_empty && !mispredict) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                j = (m_rr + i) % NUM_REQ;
                if (win < 0 && alloc_req[j]) win = j;
            end
        end
        e_gnt = (win >= 0) ? (1 << win) : 0;
        e_we  = commit_valid && idle && (commit_pd != 0);
        chk("alloc_gnt", 32'(alloc_gnt), 32'(e_gnt));
        chk("fl_read_en", 32'(fl_read_en), 32'(win >= 0));
        chk("alloc_pd", 32'(alloc_pd), (win >= 0) ? 32'(fl_pd_new_out) : 0);
        chk("commit_ready", 32'(commit_ready), 32'(idle));
        chk("fl_write_en", 32'(fl_write_en), 32'(e_we));
        chk("fl_data_in", 32'(fl_data_in), e_we ? 32'(commit_pd) : 0);
        chk("ckpt_full", 32'(ckpt_full), 32'(q.size() == NUM_CKPT));
        chk("ckpt_tag", 32'(ckpt_tag), 32'(m_tail));
        chk("busy", 32'(busy), 32'(m_rec != 0));
        chk("fl_mispredict", 32'(fl_mispredict), 32'(m_rec == 2));
        chk("fl_re_r_ptr", 32'(fl_re_r_ptr),
            (m_rec == 2) ? 32'(m_recptr) : 0);
        chk("fl_re_w_ptr", 32'(fl_re_w_ptr),
            (m_rec == 2) ? 32'(fl_w_ptr_out) : 0);
`ifdef FREE_LIST_CTRL_STATS_EN
        chk("stat_empty_stall", stat_empty_stall,
            (m_stall > 32'hffff_ffff) ? 32'hffff_ffff : 32'(m_stall));
        chk("stat_recover", 32'(stat_recover),
            (m_nrec > 16'hffff) ? 32'hffff : 32'(m_nrec));
`endif
        if (alloc_req != 0 && fl_empty) m_stall++;
        if (win >= 0) m_rr = (win + 1) % NUM_REQ;
        post = (win >= 0) ? ((fl_r_ptr_out == 127) ? 1 : fl_r_ptr_out + 1)
                          : int'(fl_r_ptr_out);
        if (m_rec > 0) m_rec--;
        if (idle && mispredict) begin
            idx = -1;
            foreach (q[k]) if (q[k].tag == int'(mispredict_tag)) idx = k;
            if (idx >= 0) begin
                m_recptr = q[idx].ptr;
                while (q.size() > idx + 1) void'(q.pop_back());
            end
            m_tail = (int'(mispredict_tag) + 1) % NUM_CKPT;
            m_rec  = 2;
            m_nrec++;
        end else begin
            ok_alloc = idle && ckpt_alloc && (q.size() < NUM_CKPT);
            if (ckpt_release && q.size() > 0) void'(q.pop_front());
            if (ok_alloc) begin
                q.push_back('{tag: m_tail, ptr: post});
                m_tail = (m_tail + 1) % NUM_CKPT;
            end
        end
    endtask

    task automatic step(input logic [1:0] rq, input logic emp, input int pd,
                        input int rp, input logic cv, input int cpd,
                        input logic ca, input logic cr, input logic mp,
                        input int mt);
        @(posedge clk);
        #1;
        alloc_req      = rq;
        fl_empty       = emp;
        fl_pd_new_out  = 7'(pd);
        fl_r_ptr_out   = 7'(rp);
        fl_w_ptr_out   = 7'($urandom_range(127));
        commit_valid   = cv;
        commit_pd      = 7'(cpd);
        ckpt_alloc     = ca;
        ckpt_release   = cr;
        mispredict     = mp;
        mispredict_tag = 2'(mt);
        @(negedge clk);
        check_and_update();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(alloc_gnt), 0);
        chk("rst_tag", 32'(ckpt_tag), 0);
        chk("rst_full", 32'(ckpt_full), 0);
        chk("rst_flmp", 32'(fl_mispredict), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int mt;
        model_reset();
        do_reset();

        // Round-robin grants with both requesters active.
        step(2'b11, 0, 32, 5, 0, 0, 0, 0, 0, 0);
        chk("rr_first_gnt", 32'(alloc_gnt), 32'b01);
        chk("rr_first_pd", 32'(alloc_pd), 32);
        step(2'b11, 0, 33, 6, 0, 0, 0, 0, 0, 0);
        chk("rr_second_gnt", 32'(alloc_gnt), 32'b10);
        chk("rr_second_pd", 32'(alloc_pd), 33);
        chk("rr_second_rd", 32'(fl_read_en), 1);

        // Empty free list blocks grants.
        step(2'b11, 1, 34, 7, 0, 0, 0, 0, 0, 0);
        chk("empty_gnt", 32'(alloc_gnt), 0);
        chk("empty_rd", 32'(fl_read_en), 0);

        // Commit of p0 is acknowledged but not written.
        step(2'b00, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        chk("p0_ready", 32'(commit_ready), 1);
        chk("p0_we", 32'(fl_write_en), 0);
        step(2'b00, 0, 0, 7, 1, 45, 0, 0, 0, 0);
        chk("p45_we", 32'(fl_write_en), 1);
        chk("p45_data", 32'(fl_data_in), 45);

        // Checkpoint with grant at pointer 127 wraps to 1.
        step(2'b01, 0, 50, 127, 0, 0, 1, 0, 0, 0);
        chk("wrap_tag", 32'(ckpt_tag), 0);
        step(2'b00, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        step(2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("wrap_reptr", 32'(fl_re_r_ptr), 1);
        step(2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(2'b00, 0, 0, 1, 0, 0, 0, 1, 0, 0);

        // Fill the checkpoint queue, overflow, release.
        for (int i = 0; i < 4; i++) step(2'b00, 0, 0, 20 + i, 0, 0, 1, 0, 0, 0);
        step(2'b00, 0, 0, 30, 0, 0, 1, 0, 0, 0);
        chk("full_set", 32'(ckpt_full), 1);
        step(2'b00, 0, 0, 30, 0, 0, 0, 1, 0, 0);
        step(2'b00, 0, 0, 30, 0, 0, 0, 0, 0, 0);
        chk("full_clr", 32'(ckpt_full), 0);

        // Mispredict to the middle checkpoint.
        do_reset();
        step(2'b00, 0, 0, 10, 0, 0, 1, 0, 0, 0);
        step(2'b00, 0, 0, 14, 0, 0, 1, 0, 0, 0);
        step(2'b00, 0, 0, 20, 0, 0, 1, 0, 0, 0);
        step(2'b11, 0, 60, 21, 1, 9, 1, 0, 1, 1);
        chk("mp_T_gnt", 32'(alloc_gnt), 0);
        step(2'b11, 0, 60, 21, 1, 9, 0, 0, 0, 0);
        chk("mp_T1_flmp", 32'(fl_mispredict), 1);
        chk("mp_T1_reptr", 32'(fl_re_r_ptr), 14);
        chk("mp_T1_gnt", 32'(alloc_gnt), 0);
        chk("mp_T1_ready", 32'(commit_ready), 0);
        step(2'b11, 0, 60, 21, 1, 9, 0, 0, 0, 0);
        chk("mp_T2_flmp", 32'(fl_mispredict), 0);
        chk("mp_T2_busy", 32'(busy), 1);
        chk("mp_T2_gnt", 32'(alloc_gnt), 0);
        step(2'b11, 0, 60, 21, 1, 9, 1, 0, 0, 0);
        chk("mp_T3_gnt", 32'(alloc_gnt), 32'b01);
        chk("mp_T3_tag", 32'(ckpt_tag), 2);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic mp;
            mp = (q.size() > 0) && ($urandom_range(7) == 0);
            mt = mp ? q[$urandom_range(q.size() - 1)].tag : int'($urandom_range(3));
            step(2'($urandom), ($urandom_range(3) == 0),
                 int'($urandom_range(127)),
                 ($urandom_range(7) == 0) ? 127 : int'($urandom_range(1, 127)),
                 1'($urandom), ($urandom_range(5) == 0) ? 0 : int'($urandom_range(127)),
                 1'($urandom), ($urandom_range(2) == 0), mp, mt);
        end

        // Reset asserted in the middle of a recovery.
        do_reset();
        step(2'b00, 0, 0, 40, 0, 0, 1, 0, 0, 0);
        step(2'b00, 0, 0, 40, 0, 0, 0, 0, 1, 0);
        step(2'b00, 0, 0, 40, 0, 0, 0, 0, 0, 0);
        chk("midrec_busy", 32'(busy), 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("midrec_rst_busy", 32'(busy), 0);
        chk("midrec_rst_flmp", 32'(fl_mispredict), 0);
        chk("midrec_rst_tag", 32'(ckpt_tag), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        step(2'b10, 0, 77, 40, 1, 5, 1, 0, 0, 0);
        chk("post_rst_gnt", 32'(alloc_gnt), 32'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
